cdb_arbiter: RTL and testbench

- Collects completed results from the functional units (ALU, multiplier, divider, memory unit) and drives the single common data bus (CDB).
- The CDB feeds the ROB and all reservation stations.
- Picks at most one result per cycle using a rotating round-robin priority, registers it onto the CDB, and returns a one-cycle read acknowledge to the winning unit.
- Replaces the fixed-priority ALU-over-MUL CDB write logic in the core top level.

---
 rtl/cdb_arbiter_if.sv | 41 ++++
 rtl/cdb_arbiter.sv | 115 +++++++++++
 tb/tb_cdb_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Result-source and common-data-bus signal bundle for the CDB arbiter.
// The arbiter takes the slave side; functional units and consumers take the master side.
interface cdb_arbiter_if #(
   parameter int NUM_SRC  = 4,
   parameter int ROB_IX_W = 3,
   parameter int DATA_W   = 32
);
   logic [NUM_SRC-1:0]          src_valid_in;
   logic [NUM_SRC*ROB_IX_W-1:0] src_rob_ix_in;
   logic [NUM_SRC*DATA_W-1:0]   src_data_in;
   logic                        flush_in;
   logic [NUM_SRC-1:0]          src_read_out;
   logic                        cdb_valid_out;
   logic [ROB_IX_W-1:0]         cdb_rob_ix_out;
   logic [DATA_W-1:0]           cdb_value_out;
   logic [15:0]                 cdb_count_out;

   modport master (
      output src_valid_in,
      output src_rob_ix_in,
      output src_data_in,
      output flush_in,
      input  src_read_out,
      input  cdb_valid_out,
      input  cdb_rob_ix_out,
      input  cdb_value_out,
      input  cdb_count_out
   );

   modport slave (
      input  src_valid_in,
      input  src_rob_ix_in,
      input  src_data_in,
      input  flush_in,
      output src_read_out,
      output cdb_valid_out,
      output cdb_rob_ix_out,
      output cdb_value_out,
      output cdb_count_out
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the single common data bus from the FU results.
// One registered broadcast per cycle; the winner gets a one-cycle read pulse.
module cdb_arbiter #(
   parameter int NUM_SRC  = 4,
   parameter int ROB_IX_W = 3,
   parameter int DATA_W   = 32
) (
   input logic        clk_in,
   input logic        rst_n_in,
   cdb_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]  eligible;
   logic                found;
   logic [PTR_W-1:0]    win;
   logic [NUM_SRC-1:0]  gnt;
   logic                hi_found;
   logic                lo_found;
   logic [PTR_W-1:0]    hi_win;
   logic [PTR_W-1:0]    lo_win;
   logic [ROB_IX_W-1:0] rob_sel;
   logic [DATA_W-1:0]   val_sel;

   logic                valid_q, valid_d;
   logic [NUM_SRC-1:0]  read_q, read_d;
   logic [ROB_IX_W-1:0] rob_q, rob_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [15:0]         cnt_q, cnt_d;

   // A source acknowledged last cycle may still show valid; mask it.
   assign eligible = bus.src_valid_in & ~read_q & {NUM_SRC{~bus.flush_in}};

   // Indices at or above the pointer beat those that wrapped below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_win   = '0;
      lo_win   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible[i]) begin
            if (i >= int'(ptr_q)) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_win   = PTR_W'(i);
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_win   = PTR_W'(i);
            end
         end
      end
      found = hi_found | lo_found;
      win   = hi_found ? hi_win : lo_win;
   end

   always_comb begin
      gnt     = '0;
      rob_sel = '0;
      val_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (found && (win == PTR_W'(i))) begin
            gnt[i]  = 1'b1;
            rob_sel = bus.src_rob_ix_in[i*ROB_IX_W +: ROB_IX_W];
            val_sel = bus.src_data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      valid_d = found;
      read_d  = gnt;
      rob_d   = rob_q;
      val_d   = val_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (found) begin
         rob_d = rob_sel;
         val_d = val_sel;
         cnt_d = cnt_q + 16'd1;
         // Explicit wrap keeps non-power-of-two source counts in range.
         if (win == PTR_W'(NUM_SRC - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q <= 1'b0;
         read_q  <= '0;
         rob_q   <= '0;
         val_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         read_q  <= read_d;
         rob_q   <= rob_d;
         val_q   <= val_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.src_read_out   = read_q;
   assign bus.cdb_valid_out  = valid_q;
   assign bus.cdb_rob_ix_out = rob_q;
   assign bus.cdb_value_out  = val_q;
   assign bus.cdb_count_out  = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single source, rotation,
// contention, flush, async reset mid-stream and count wrap.
module tb_cdb_arbiter;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   logic [2:0]  rob [4];
   logic [31:0] dat [4];

   cdb_arbiter_if #(.NUM_SRC(4), .ROB_IX_W(3), .DATA_W(32)) bus ();

   cdb_arbiter #(.NUM_SRC(4), .ROB_IX_W(3), .DATA_W(32)) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v);
      bus.src_valid_in = v;
      for (int i = 0; i < 4; i++) begin
         bus.src_rob_ix_in[i*3 +: 3]  = rob[i];
         bus.src_data_in[i*32 +: 32]  = dat[i];
      end
   endtask

   task automatic grant(input string tag, input int w, input int cnt);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      chk({tag, ".valid"}, 32'(bus.cdb_valid_out), 32'd1);
      chk({tag, ".read"},  32'(bus.src_read_out), 32'(oh));
      chk({tag, ".rob"},   32'(bus.cdb_rob_ix_out), 32'(rob[w]));
      chk({tag, ".value"}, bus.cdb_value_out, dat[w]);
      chk({tag, ".count"}, 32'(bus.cdb_count_out), 32'(cnt));
   endtask

   task automatic idle(input string tag, input int cnt);
      chk({tag, ".valid"}, 32'(bus.cdb_valid_out), 32'd0);
      chk({tag, ".read"},  32'(bus.src_read_out), 32'd0);
      chk({tag, ".count"}, 32'(bus.cdb_count_out), 32'(cnt));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 4; i++) begin
         rob[i] = 3'(2*i + 1);
         dat[i] = 32'hA000_0000 + 32'(i);
      end
      bus.flush_in = 1'b0;
      bus.src_rob_ix_in = '0;
      bus.src_data_in = '0;
      rst_n = 1'b0;
      drive(4'b1111);

      // Reset held with all sources valid while the clock runs
      #1;
      idle("rst_t1", 0);
      repeat (3) @(negedge clk);
      idle("rst_clk", 0);
      chk("rst_rob", 32'(bus.cdb_rob_ix_out), 32'd0);
      chk("rst_val", bus.cdb_value_out, 32'd0);

      // Release: rotation 0,1,2,3,0 with all valid continuously
      rst_n = 1'b1;
      @(negedge clk); grant("rr0", 0, 1);
      @(negedge clk); grant("rr1", 1, 2);
      @(negedge clk); grant("rr2", 2, 3);
      @(negedge clk); grant("rr3", 3, 4);
      @(negedge clk); grant("rr4", 0, 5);
      drive(4'b0000);
      @(negedge clk);
      idle("none", 5);
      chk("hold_rob", 32'(bus.cdb_rob_ix_out), 32'(rob[0]));
      chk("hold_val", bus.cdb_value_out, dat[0]);

      // Single source held one cycle past its read pulse
      rob[1] = 3'd5;
      dat[1] = 32'hDEAD_BEEF;
      drive(4'b0010);
      @(negedge clk); grant("single", 1, 6);
      @(negedge clk); idle("no_regrant", 6);
      chk("regrant_rob", 32'(bus.cdb_rob_ix_out), 32'd5);
      chk("regrant_val", bus.cdb_value_out, 32'hDEAD_BEEF);
      drive(4'b0000);

      // Source 2 granted, then 0 and 3 contend: 3 first
      @(negedge clk);
      drive(4'b0100);
      @(negedge clk); grant("cont2", 2, 7);
      drive(4'b1001);
      @(negedge clk); grant("cont3", 3, 8);
      drive(4'b0001);
      @(negedge clk); grant("cont0", 0, 9);
      drive(4'b0000);

      // Grant 3 so the pointer sits at 0, then flush with 0 and 1 valid
      @(negedge clk);
      drive(4'b1000);
      @(negedge clk); grant("pre_flush", 3, 10);
      drive(4'b0011);
      bus.flush_in = 1'b1;
      @(negedge clk); idle("flush", 10);
      bus.flush_in = 1'b0;
      @(negedge clk); grant("post_flush0", 0, 11);
      drive(4'b0010);
      @(negedge clk); grant("post_flush1", 1, 12);
      drive(4'b0000);

      // Asynchronous reset between edges while a broadcast is showing
      @(negedge clk);
      drive(4'b0100);
      @(negedge clk); grant("pre_arst", 2, 13);
      #2 rst_n = 1'b0;
      #1;
      idle("arst", 0);
      chk("arst_rob", 32'(bus.cdb_rob_ix_out), 32'd0);
      chk("arst_val", bus.cdb_value_out, 32'd0);
      @(negedge clk);
      idle("arst_held", 0);
      rst_n = 1'b1;
      @(negedge clk); grant("post_arst", 2, 1);

      // Two alternating sources broadcast every cycle until the count wraps
      drive(4'b0011);
      repeat (65534) @(negedge clk);
      chk("cnt_max", 32'(bus.cdb_count_out), 32'h0000_FFFF);
      @(negedge clk);
      chk("cnt_wrap", 32'(bus.cdb_count_out), 32'd0);
      chk("wrap_valid", 32'(bus.cdb_valid_out), 32'd1);
      drive(4'b0000);
      @(negedge clk);
      idle("wrap_idle", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
